// File: rtl/microstepper_pkg.sv
// Shared state encoding, default widths and helpers for the step sequencer.
package microstepper_pkg;

  localparam int DEF_TICK_W  = 24;
  localparam int DEF_COUNT_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    DIR_SETUP,
    PULSE_HIGH,
    PULSE_LOW
  } state_e;

  function automatic logic [7:0] max1(input logic [7:0] x);
    return (x == 8'd0) ? 8'd1 : x;
  endfunction

endpackage

// File: rtl/period_ramp.sv
// Step period register with a saturating signed delta ramp.
// A negative sum or one below the floor lands on i_min.
module period_ramp
  import microstepper_pkg::*;
#(
  parameter int TICK_W = DEF_TICK_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_load,
  input  logic [TICK_W-1:0] i_load_period,
  input  logic [TICK_W-1:0] i_load_delta,
  input  logic              i_step,
  input  logic [TICK_W-1:0] i_min,
  output logic [TICK_W-1:0] o_period
);

  logic [TICK_W-1:0]        r_period;
  logic [TICK_W-1:0]        r_delta;
  logic signed [TICK_W+1:0] w_sum;
  logic [TICK_W-1:0]        w_next;

  // Two guard bits: sign and overflow above the unsigned range.
  assign w_sum = $signed({2'b00, r_period})
               + $signed({{2{r_delta[TICK_W-1]}}, r_delta});

  always_comb begin
    w_next = w_sum[TICK_W-1:0];
    if (w_sum[TICK_W+1])
      w_next = i_min;
    else if (w_sum[TICK_W])
      w_next = '1;
    else if (w_sum[TICK_W-1:0] < i_min)
      w_next = i_min;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_period <= '0;
      r_delta  <= '0;
    end else if (i_load) begin
      r_period <= i_load_period;
      r_delta  <= i_load_delta;
    end else if (i_step) begin
      r_period <= w_next;
    end
  end

  assign o_period = r_period;

endmodule

// File: rtl/step_sequencer.sv
// Motion command sequencer: step/dir/enable with pulse width,
// dir setup time and a linear period ramp.
module step_sequencer
  import microstepper_pkg::*;
#(
  parameter int TICK_W  = DEF_TICK_W,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [COUNT_W-1:0] cmd_steps,
  input  logic [TICK_W-1:0]  cmd_period,
  input  logic [TICK_W-1:0]  cmd_delta,
  input  logic [7:0]         config_pulse_len,
  input  logic [7:0]         config_dir_setup,
  input  logic [TICK_W-1:0]  config_min_period,
  input  logic               abort,
  input  logic               faultn,
  output logic               step,
  output logic               dir,
  output logic               enable_out,
  output logic               busy,
  output logic [COUNT_W-1:0] steps_remaining,
  output logic               done,
  output logic               aborted
);

  state_e              r_state;
  logic [TICK_W-1:0]   r_cnt;
  logic                r_pend;

  logic                w_stop;
  logic                w_accept;
  logic [TICK_W-1:0]   w_plen;
  logic [TICK_W-1:0]   w_dsu;
  logic [TICK_W-1:0]   w_floor;
  logic [TICK_W-1:0]   w_cur;
  logic [TICK_W-1:0]   w_per;
  logic                w_low_end;
  logic                w_ramp_step;
  logic [COUNT_W-1:0]  w_rem_dec;

  assign w_stop    = abort || !faultn;
  assign cmd_ready = (r_state == IDLE) && faultn && !abort;
  assign w_accept  = cmd_valid && cmd_ready;

  assign w_plen  = TICK_W'(max1(config_pulse_len));
  assign w_dsu   = TICK_W'(max1(config_dir_setup));
  assign w_floor = w_plen + TICK_W'(1);
  assign w_per   = (w_cur < w_floor) ? w_floor : w_cur;

  assign w_low_end   = (r_state == PULSE_LOW) && (r_cnt >= w_per);
  assign w_ramp_step = w_low_end && !w_stop && (steps_remaining != '0);

  assign w_rem_dec = (steps_remaining == '0) ? '0
                   : steps_remaining - COUNT_W'(1);

  period_ramp #(
    .TICK_W(TICK_W)
  ) u_ramp (
    .clk           (clk),
    .resetn        (resetn),
    .i_load        (w_accept),
    .i_load_period (cmd_period),
    .i_load_delta  (cmd_delta),
    .i_step        (w_ramp_step),
    .i_min         (config_min_period),
    .o_period      (w_cur)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_pend          <= 1'b0;
      step            <= 1'b0;
      dir             <= 1'b0;
      enable_out      <= 1'b0;
      busy            <= 1'b0;
      steps_remaining <= '0;
      done            <= 1'b0;
      aborted         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!faultn)
        enable_out <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            aborted    <= 1'b0;
            enable_out <= 1'b1;
            r_cnt      <= TICK_W'(1);
            if (cmd_steps == '0) begin
              done <= 1'b1;
            end else if (cmd_dir != dir) begin
              busy            <= 1'b1;
              dir             <= cmd_dir;
              steps_remaining <= cmd_steps;
              r_state         <= DIR_SETUP;
            end else begin
              busy            <= 1'b1;
              step            <= 1'b1;
              steps_remaining <= cmd_steps - COUNT_W'(1);
              r_state         <= PULSE_HIGH;
            end
          end
        end
        DIR_SETUP: begin
          if (w_stop) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (r_cnt >= w_dsu) begin
            r_state         <= PULSE_HIGH;
            step            <= 1'b1;
            r_cnt           <= TICK_W'(1);
            steps_remaining <= w_rem_dec;
          end else begin
            r_cnt <= r_cnt + TICK_W'(1);
          end
        end
        PULSE_HIGH: begin
          r_cnt <= r_cnt + TICK_W'(1);
          // A stop seen mid-pulse waits for the full high time.
          if (r_cnt >= w_plen) begin
            step   <= 1'b0;
            r_pend <= 1'b0;
            if (r_pend || w_stop) begin
              r_state <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              aborted <= 1'b1;
            end else begin
              r_state <= PULSE_LOW;
            end
          end else if (w_stop) begin
            r_pend <= 1'b1;
          end
        end
        PULSE_LOW: begin
          if (w_stop) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (w_low_end) begin
            if (steps_remaining == '0) begin
              r_state <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_state         <= PULSE_HIGH;
              step            <= 1'b1;
              r_cnt           <= TICK_W'(1);
              steps_remaining <= w_rem_dec;
            end
          end else begin
            r_cnt <= r_cnt + TICK_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench: per-command rise schedule model compared
// against the sequencer outputs on every cycle.
module tb_step_sequencer;

  localparam int TW  = 24;
  localparam int CW  = 24;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dir = 1'b0;
  logic [CW-1:0] cmd_steps = '0;
  logic [TW-1:0] cmd_period = '0;
  logic [TW-1:0] cmd_delta = '0;
  logic [7:0]    config_pulse_len = 8'd2;
  logic [7:0]    config_dir_setup = 8'd1;
  logic [TW-1:0] config_min_period = '0;
  logic          abort = 1'b0;
  logic          faultn = 1'b1;
  logic          step, dir, enable_out, busy, done, aborted;
  logic [CW-1:0] steps_remaining;

  step_sequencer #(.TICK_W(TW), .COUNT_W(CW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_dir           (cmd_dir),
    .cmd_steps         (cmd_steps),
    .cmd_period        (cmd_period),
    .cmd_delta         (cmd_delta),
    .config_pulse_len  (config_pulse_len),
    .config_dir_setup  (config_dir_setup),
    .config_min_period (config_min_period),
    .abort             (abort),
    .faultn            (faultn),
    .step              (step),
    .dir               (dir),
    .enable_out        (enable_out),
    .busy              (busy),
    .steps_remaining   (steps_remaining),
    .done              (done),
    .aborted           (aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Model of the current command: absolute rise cycles and end cycle.
  bit m_valid = 1'b0;
  bit m_dir = 1'b0;
  bit m_ab = 1'b0;
  int m_t1 = 0;
  int m_done = 0;
  int m_steps = 0;
  int m_pl = 1;
  int m_en_off = BIG;
  int m_rise[$];

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
  endtask

  function automatic int clampp(longint v, int mn);
    if (v < mn) return mn;
    if (v > 64'hFFFFFF) return 'hFFFFFF;
    return int'(v);
  endfunction

  always @(negedge clk) begin : cmp
    int t, e_rem;
    bit e_step, e_busy, e_done, e_ab, e_en, e_dir, e_rdy;
    if (chk_en) begin
      t = cyc;
      e_step = 1'b0;
      e_rem = m_valid ? m_steps : 0;
      foreach (m_rise[i]) begin
        if (t >= m_rise[i] && t < m_rise[i] + m_pl) e_step = 1'b1;
        if (m_rise[i] <= t) e_rem--;
      end
      e_busy = m_valid && m_steps > 0 && t >= m_t1 && t < m_done;
      e_done = m_valid && t == m_done;
      e_ab   = m_valid && m_ab && t >= m_done;
      e_en   = m_valid && t < m_en_off;
      e_dir  = m_valid && m_dir;
      e_rdy  = !e_busy && faultn && !abort;
      chk("step", step, e_step);
      chk("dir", dir, e_dir);
      chk("enable", enable_out, e_en);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("aborted", aborted, e_ab);
      chk("steps_rem", steps_remaining, e_rem);
      chk("cmd_ready", cmd_ready, e_rdy);
    end
  end

  // kind: 0 plain, 1 abort, 2 fault, 3 reset.
  // rel < 0 picks the (-rel)th rise cycle, else an offset from t1.
  task automatic run_cmd(bit d, int steps, int per, int dl, int pl,
                         int dsu, int minp, int kind_in, int rel);
    int t1, pe, de, p, nxt, ndone, a, dn, w, end_t, kind;
    bit old_dir, ab;
    int rs[$];
    kind = kind_in;
    config_pulse_len  = 8'(pl);
    config_dir_setup  = 8'(dsu);
    config_min_period = TW'(minp);
    w = 0;
    while (!cmd_ready && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = CW'(steps);
    cmd_period = TW'(per);
    cmd_delta  = TW'(dl);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t1 = cyc;
    pe = (pl == 0) ? 1 : pl;
    de = (dsu == 0) ? 1 : dsu;
    old_dir = m_valid && m_dir;
    p = per;
    nxt = t1 + ((d != old_dir) ? de : 0);
    for (int i = 0; i < steps; i++) begin
      rs.push_back(nxt);
      nxt += (p > pe + 1) ? p : pe + 1;
      p = clampp(longint'(p) + dl, minp);
    end
    ndone = (steps == 0) ? t1 : nxt;
    if (steps == 0) kind = 0;
    a = BIG;
    if (kind != 0) begin
      if (rel < 0) a = rs[-rel - 1];
      else a = t1 + (rel % (ndone - t1));
    end
    dn = ndone;
    ab = 1'b0;
    if (kind == 1 || kind == 2) begin
      ab = 1'b1;
      dn = a + 1;
      foreach (rs[i]) if (rs[i] <= a && a < rs[i] + pe) dn = rs[i] + pe;
      while (rs.size() > 0 && rs[rs.size()-1] > a) void'(rs.pop_back());
    end
    m_valid  = 1'b1;
    m_dir    = (steps == 0) ? old_dir : d;
    m_t1     = t1;
    m_steps  = steps;
    m_pl     = pe;
    m_rise   = rs;
    m_done   = dn;
    m_ab     = ab;
    m_en_off = (kind == 2) ? a + 1 : BIG;
    end_t = (kind == 3) ? a + 1 : dn + 2;
    while (cyc < end_t) begin
      if (cyc == a) begin
        if (kind == 1) abort = 1'b1;
        if (kind == 2) faultn = 1'b0;
        if (kind == 3) resetn = 1'b0;
      end
      @(posedge clk); #1;
      if (kind == 3 && cyc == a + 1) begin
        resetn  = 1'b1;
        m_valid = 1'b0;
        m_ab    = 1'b0;
        m_steps = 0;
        m_done  = 0;
        m_rise.delete();
      end
      if (cyc >= m_done) begin
        abort  = 1'b0;
        faultn = 1'b1;
      end
    end
  endtask

  initial begin
    int s, k, dl;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    chk_en = 1'b1;
    chk("rst_step", step, 0);
    chk("rst_enable", enable_out, 0);
    chk("rst_rem", steps_remaining, 0);

    // 3 steps, period 10, pulse 2
    run_cmd(0, 3, 10, 0, 2, 1, 0, 0, 0);
    chk("t1_rise2", m_rise[1] - m_t1, 10);
    chk("t1_rise3", m_rise[2] - m_t1, 20);
    chk("t1_done", m_done - m_t1, 30);

    // direction change with setup 5
    run_cmd(1, 1, 8, 0, 2, 5, 0, 0, 0);
    chk("t2_rise", m_rise[0] - m_t1, 5);
    chk("t2_done", m_done - m_t1, 13);

    // zero steps
    run_cmd(1, 0, 8, 0, 2, 5, 0, 0, 0);
    chk("t3_done", m_done - m_t1, 0);
    chk("t3_aborted", aborted, 0);

    // ramp down to the floor
    run_cmd(1, 4, 100, -30, 2, 1, 50, 0, 0);
    chk("t4_iv1", m_rise[1] - m_rise[0], 100);
    chk("t4_iv2", m_rise[2] - m_rise[1], 70);
    chk("t4_iv3", m_rise[3] - m_rise[2], 50);
    chk("t4_iv4", m_done - m_rise[3], 50);
    run_cmd(1, 2, 3, 0, 4, 1, 0, 0, 0);
    chk("t4_short", m_rise[1] - m_rise[0], 5);

    // abort on the 3rd pulse's first high cycle
    run_cmd(1, 10, 20, 0, 4, 1, 0, 1, -3);
    chk("t5_done", m_done - m_rise[2], 4);
    chk("t5_rem", steps_remaining, 7);
    chk("t5_aborted", aborted, 1);

    // fault in PULSE_LOW
    run_cmd(1, 5, 20, 0, 3, 1, 0, 2, 5);
    chk("t5f_done", m_done - m_t1, 6);
    chk("t5f_enable", enable_out, 0);
    chk("t5f_rem", steps_remaining, 4);

    // fault in IDLE blocks accept
    run_cmd(1, 1, 6, 0, 2, 1, 0, 0, 0);
    faultn    = 1'b0;
    cmd_valid = 1'b1;
    cmd_steps = CW'(5);
    m_en_off  = cyc + 1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    faultn    = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_fault_busy", busy, 0);

    // reset on the second rise
    run_cmd(1, 4, 12, 0, 3, 2, 0, 3, -2);
    chk("t6_busy", busy, 0);
    chk("t6_dir", dir, 0);
    run_cmd(0, 2, 9, 1, 2, 1, 0, 0, 0);
    chk("t6_rem", steps_remaining, 0);

    for (int i = 0; i < 40; i++) begin
      s = int'($urandom_range(0, 6));
      k = int'($urandom_range(0, 7));
      if (k < 5) k = 0;
      else k = k - 4;
      dl = int'($urandom_range(0, 16)) - 8;
      run_cmd(1'($urandom_range(0, 1)), s, int'($urandom_range(0, 30)),
              dl, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 15)), k, int'($urandom_range(0, 500)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
